// File: rtl/alu_op_decode_stage.sv
// ID-stage decoder for the EX-stage ALU: turns one RV32IM word into an ALU
// select code plus operand/memory controls and holds it in the ID/EX slot.
`timescale 1ns/1ps
module alu_op_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_alu_select,
    output logic            out_data1_pc,
    output logic            out_data2_imm,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_alu_en,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // ALU SELECT codes: M-extension ops are {2'b10, funct3}; 2'b11 in [4:3] forwards DATA2.
    localparam logic [4:0] SEL_ADD  = 5'b00000;
    localparam logic [4:0] SEL_SUB  = 5'b00001;
    localparam logic [4:0] SEL_SLL  = 5'b00010;
    localparam logic [4:0] SEL_SLT  = 5'b00011;
    localparam logic [4:0] SEL_SLTU = 5'b00100;
    localparam logic [4:0] SEL_XOR  = 5'b00101;
    localparam logic [4:0] SEL_SRL  = 5'b00110;
    localparam logic [4:0] SEL_SRA  = 5'b00111;
    localparam logic [4:0] SEL_OR   = 5'b01000;
    localparam logic [4:0] SEL_AND  = 5'b01001;
    localparam logic [4:0] SEL_FWD  = 5'b11000;

    typedef struct packed {
        logic [4:0]      sel;
        logic            d1pc;
        logic            d2imm;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rw;
        logic            mr;
        logic            mw;
        logic            en;
        logic            ill;
        logic [XLEN-1:0] pc;
    } slot_t;

    function automatic logic [4:0] base_sel(input logic [2:0] f3);
        case (f3)
            3'b000:  base_sel = SEL_ADD;
            3'b001:  base_sel = SEL_SLL;
            3'b010:  base_sel = SEL_SLT;
            3'b011:  base_sel = SEL_SLTU;
            3'b100:  base_sel = SEL_XOR;
            3'b101:  base_sel = SEL_SRL;
            3'b110:  base_sel = SEL_OR;
            default: base_sel = SEL_AND;
        endcase
    endfunction

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_sh;
    logic            ill, alu, wr;
    slot_t           dec;
    slot_t           slot_d, slot_q;
    logic            valid_d, valid_q;
    logic            accept;

    assign opc    = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign imm_sh = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    always_comb begin
        dec     = '0;
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.rd  = in_instr[11:7];
        dec.pc  = in_pc;
        ill     = 1'b0;
        alu     = 1'b0;
        wr      = 1'b0;
        case (opc)
            OPC_OP: begin
                alu = 1'b1;
                wr  = 1'b1;
                case (f7)
                    7'b0000000: dec.sel = base_sel(f3);
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec.sel = SEL_SUB;
                        else if (f3 == 3'b101) dec.sel = SEL_SRA;
                        else                   ill = 1'b1;
                    end
                    7'b0000001: dec.sel = {2'b10, f3};
                    default:    ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                alu       = 1'b1;
                wr        = 1'b1;
                dec.d2imm = 1'b1;
                dec.imm   = imm_i;
                dec.sel   = base_sel(f3);
                // Shift-immediates carry only the shamt; imm[11:5] is an opcode extension.
                if (f3 == 3'b001) begin
                    dec.imm = imm_sh;
                    ill     = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec.imm = imm_sh;
                    if (f7 == 7'b0100000)      dec.sel = SEL_SRA;
                    else if (f7 != 7'b0000000) ill = 1'b1;
                end
            end
            OPC_LUI: begin
                alu = 1'b1; wr = 1'b1;
                dec.sel = SEL_FWD; dec.d2imm = 1'b1; dec.imm = imm_u;
            end
            OPC_AUIPC: begin
                alu = 1'b1; wr = 1'b1;
                dec.d1pc = 1'b1; dec.d2imm = 1'b1; dec.imm = imm_u;
            end
            OPC_LOAD: begin
                alu = 1'b1; wr = 1'b1;
                dec.d2imm = 1'b1; dec.imm = imm_i; dec.mr = 1'b1;
            end
            OPC_STORE: begin
                alu = 1'b1;
                dec.d2imm = 1'b1; dec.imm = imm_s; dec.mw = 1'b1;
            end
            // Owned by the branch/system units: pass through with ALU disabled.
            OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_FENCE: ;
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec.sel   = SEL_ADD;
            dec.d1pc  = 1'b0;
            dec.d2imm = 1'b0;
            dec.imm   = '0;
            dec.mr    = 1'b0;
            dec.mw    = 1'b0;
            dec.ill   = 1'b1;
        end else begin
            dec.en = alu;
            dec.rw = wr && (dec.rd != 5'd0);
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        slot_d  = slot_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            slot_d  = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_alu_select = slot_q.sel;
    assign out_data1_pc   = slot_q.d1pc;
    assign out_data2_imm  = slot_q.d2imm;
    assign out_imm        = slot_q.imm;
    assign out_rs1        = slot_q.rs1;
    assign out_rs2        = slot_q.rs2;
    assign out_rd         = slot_q.rd;
    assign out_reg_write  = slot_q.rw;
    assign out_mem_read   = slot_q.mr;
    assign out_mem_write  = slot_q.mw;
    assign out_alu_en     = slot_q.en;
    assign out_illegal    = slot_q.ill;
    assign out_pc         = slot_q.pc;
endmodule

// File: tb/tb_alu_op_decode_stage.sv
// Bench for alu_op_decode_stage: directed scenarios plus random traffic checked
// against a table-driven decode model and a slot-occupancy model.
`timescale 1ns/1ps
module tb_alu_op_decode_stage;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid, out_data1_pc, out_data2_imm;
    logic [4:0]  out_alu_select, out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm, out_pc;
    logic        out_reg_write, out_mem_read, out_mem_write, out_alu_en, out_illegal;

    alu_op_decode_stage #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu_select(out_alu_select),
        .out_data1_pc(out_data1_pc), .out_data2_imm(out_data2_imm), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_alu_en(out_alu_en),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    always #5 CLK = ~CLK;

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SRA = 5'd7, MUL = 5'd16, DIV = 5'd20, FWD = 5'd24;
    logic [4:0] base_tbl [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    logic [4:0] mext_tbl [8] = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
    logic [6:0] opc_tbl [12] = '{7'h33, 7'h33, 7'h13, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23,
                                 7'h63, 7'h6F, 7'h67, 7'h73};

    typedef struct {
        logic [4:0]  sel;
        logic        d1pc, d2imm;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, en, ill;
        logic [31:0] pc;
    } exp_t;

    int   n_checks = 0;
    int   n_pass = 0;
    logic m_valid = 1'b0;
    exp_t m_slot;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [31:0] shamt = ins & 32'h01F0_0000;
        e = '{sel: ADD, imm: 0, rs1: ins[19:15], rs2: ins[24:20], rd: ins[11:7], pc: pc, default: 0};
        shamt = shamt >> 20;
        case (ins[6:0])
            7'h33: begin
                e.en = 1; e.rw = 1;
                if (f7 == 7'h00) e.sel = base_tbl[f3];
                else if (f7 == 7'h01) e.sel = mext_tbl[f3];
                else if (f7 == 7'h20 && f3 == 0) e.sel = SUB;
                else if (f7 == 7'h20 && f3 == 5) e.sel = SRA;
                else e.ill = 1;
            end
            7'h13: begin
                e.en = 1; e.rw = 1; e.d2imm = 1;
                e.sel = base_tbl[f3];
                e.imm = $signed(ins) >>> 20;
                if (f3 == 1 || f3 == 5) begin
                    e.imm = shamt;
                    if (f3 == 5 && f7 == 7'h20) e.sel = SRA;
                    else if (f7 != 0) e.ill = 1;
                end
            end
            7'h37: begin e.en = 1; e.rw = 1; e.d2imm = 1; e.sel = FWD; e.imm = ins & 32'hFFFF_F000; end
            7'h17: begin e.en = 1; e.rw = 1; e.d2imm = 1; e.d1pc = 1; e.imm = ins & 32'hFFFF_F000; end
            7'h03: begin e.en = 1; e.rw = 1; e.d2imm = 1; e.mr = 1; e.imm = $signed(ins) >>> 20; end
            7'h23: begin
                e.en = 1; e.d2imm = 1; e.mw = 1;
                e.imm = (32'($signed(ins) >>> 25) << 5) + 32'(ins[11:7]);
            end
            7'h63, 7'h6F, 7'h67, 7'h73, 7'h0F: ;
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.sel = ADD; e.en = 0; e.rw = 0; e.d1pc = 0; e.d2imm = 0; e.imm = 0; e.mr = 0; e.mw = 0;
        end
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    task automatic check_slot(input string pfx);
        check({pfx, "_sel"}, 32'(out_alu_select), 32'(m_slot.sel));
        check({pfx, "_d1pc"}, 32'(out_data1_pc), 32'(m_slot.d1pc));
        check({pfx, "_d2imm"}, 32'(out_data2_imm), 32'(m_slot.d2imm));
        check({pfx, "_imm"}, out_imm, m_slot.imm);
        check({pfx, "_regs"}, {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, m_slot.rs1, m_slot.rs2, m_slot.rd});
        check({pfx, "_ctl"}, {27'd0, out_reg_write, out_mem_read, out_mem_write, out_alu_en, out_illegal},
              {27'd0, m_slot.rw, m_slot.mr, m_slot.mw, m_slot.en, m_slot.ill});
        check({pfx, "_pc"}, out_pc, m_slot.pc);
    endtask

    // One clock: drive at negedge, check in_ready, update the model at posedge, check outputs.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic fl, input logic rdy);
        @(negedge CLK);
        in_valid = v; in_instr = ins; in_pc = p; flush = fl; out_ready = rdy;
        #1 check("in_ready", 32'(in_ready), 32'(!m_valid || rdy));
        @(posedge CLK);
        if (fl) m_valid = 1'b0;
        else if (v && (!m_valid || rdy)) begin m_valid = 1'b1; m_slot = ref_decode(ins, p); end
        else if (rdy) m_valid = 1'b0;
        #1 check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) check_slot("slot");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_sel"}, 32'(out_alu_select), 0);
        check({tag, "_imm"}, out_imm, 0);
        check({tag, "_pc"}, out_pc, 0);
        check({tag, "_misc"}, {14'd0, out_rs1, out_rs2, out_rd, out_data1_pc, out_data2_imm,
              out_reg_write, out_mem_read, out_mem_write, out_alu_en, out_illegal}, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom();
        int k = $urandom_range(0, 12);
        r[6:0] = (k == 12) ? 7'($urandom()) : opc_tbl[k];
        if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return r;
    endfunction

    initial begin
        #1 check_all_zero("reset");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Back-to-back add / sub / mul with out_ready held high.
        drive(1, 32'h002081B3, 32'h100, 0, 1);
        check("b2b_add", 32'(out_alu_select), 32'(ADD));
        check("b2b_regs", {out_rs1, out_rs2, out_rd, out_data2_imm}, {5'd1, 5'd2, 5'd3, 1'b0});
        drive(1, 32'h402081B3, 32'h104, 0, 1);
        check("b2b_sub", 32'(out_alu_select), 32'(SUB));
        drive(1, 32'h022081B3, 32'h108, 0, 1);
        check("b2b_mul", 32'(out_alu_select), 32'(MUL));
        check("b2b_valid", 32'(out_valid), 1);

        // Back-pressure with div in the slot.
        drive(1, 32'h0220C1B3, 32'h10C, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h40335293, 32'h110, 0, 0);
            check("bp_sel_div", 32'(out_alu_select), 32'(DIV));
            check("bp_in_ready", 32'(in_ready), 0);
        end
        drive(1, 32'h40335293, 32'h110, 0, 1);
        check("srai_sel", 32'(out_alu_select), 32'(SRA));
        check("srai_imm", out_imm, 3);
        check("srai_d2imm", 32'(out_data2_imm), 1);
        drive(1, 32'h123452B7, 32'h114, 0, 1);
        check("lui_sel", 32'(out_alu_select), 32'(FWD));
        check("lui_imm", out_imm, 32'h12345000);

        // Flush colliding with a full slot and an incoming instruction.
        drive(1, 32'h002081B3, 32'h118, 1, 0);
        check("flush_valid", 32'(out_valid), 0);

        // Illegal funct7 still occupies and releases the slot.
        drive(1, 32'hFE2081B3, 32'h11C, 0, 0);
        check("ill_flag", 32'(out_illegal), 1);
        check("ill_rw", 32'(out_reg_write), 0);
        drive(0, 32'h0, 32'h0, 0, 1);
        check("ill_released", 32'(out_valid), 0);

        // Asynchronous reset while holding a full slot.
        drive(1, 32'h002081B3, 32'h120, 0, 0);
        drive(0, 32'h0, 32'h0, 0, 0);
        #2 RESET = 1'b1;
        #1 check_all_zero("async_rst");
        m_valid = 1'b0;
        @(negedge CLK) RESET = 1'b0;

        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_op_decode_stage.md
Name: alu_op_decode_stage

Overview:
- ID-stage producer for the EX-stage ALU.
- Decodes one RV32IM instruction word into the 5-bit ALU SELECT code, using the shared encodings macros, plus operand-source controls and the immediate.
- Registers the result into the ID/EX pipeline slot with a valid/ready handshake and a flush.
- It is the driving end of the ALU SELECT/DATA1/DATA2 interface.

Parameters:
- XLEN, 32, instruction, PC and immediate width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction/PC pair presented.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  32  instruction PC.
- flush  input  1  kill the held and the incoming instruction.
- out_valid  output  1  ID/EX slot holds a decoded instruction.
- out_ready  input  1  EX consumes the slot this cycle.
- out_alu_select  output  5  ALU SELECT code.
- out_data1_pc  output  1  DATA1 source: 1 = PC, 0 = rs1.
- out_data2_imm  output  1  DATA2 source: 1 = immediate, 0 = rs2.
- out_imm  output  32  sign-extended or U-type immediate.
- out_rs1, out_rs2, out_rd  output  5 each  register indices.
- out_reg_write  output  1  result written to rd; 0 when rd = x0.
- out_mem_read, out_mem_write  output  1 each  load/store address ops.
- out_alu_en  output  1  instruction uses the ALU result.
- out_illegal  output  1  unsupported encoding.
- out_pc  output  32  registered PC.

Behaviour:
- Reset: while RESET is high, and immediately on assertion, every output register is 0. That includes out_valid = 0 and out_alu_select = 0.
- Reset mid-operation: the held instruction is discarded with no completion.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Latency: one cycle from accept to out_valid.
  - Payload holds stable while out_valid && !out_ready.
- Slot update at each edge, in priority order:
  - flush → out_valid = 0; any simultaneous input is dropped.
  - Accept → load decoded payload, out_valid = 1.
  - out_ready with no accept → out_valid = 0.
  - Otherwise hold.
- Back-to-back: when out_ready and in_valid are both high every cycle, throughput is one instruction per cycle with no bubble.
- Decode (combinational from in_instr, registered on accept):
  - OP (0110011), funct7 = 0000000: funct3 maps to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - OP, funct7 = 0100000: funct3 000 → SUB, 101 → SRA.
  - OP, funct7 = 0000001: funct3 maps to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - OP: data2_imm = 0.
  - OP-IMM (0010011): same funct3 map as OP with funct7 = 0, data2_imm = 1, I-immediate.
    - funct3 101 with imm[11:5] = 0100000 → SRA.
    - SLLI/SRLI/SRAI with any other imm[11:5] → illegal.
  - LUI (0110111): select = forward code (SELECT[4:3] = 11, passes DATA2), data2_imm = 1, imm = {instr[31:12], 12'b0}.
  - AUIPC (0010111): ADD, data1_pc = 1, data2_imm = 1, U-immediate.
  - LOAD (0000011): ADD, data2_imm = 1, I-immediate, mem_read = 1, reg_write = 1.
  - STORE (0100011): ADD, data2_imm = 1, S-immediate, mem_write = 1, reg_write = 0.
- out_alu_en = 1 for all of the above.
- BRANCH, JAL, JALR, SYSTEM, FENCE: alu_en = 0, select = ADD, illegal = 0. These are owned by the branch/system units.
- Any other opcode, or an undefined funct7/funct3 combination:
  - out_illegal = 1, alu_en = 0, reg_write = 0.
  - The instruction still occupies the slot and completes the handshake.
- out_reg_write is forced to 0 when rd = 0.
- Immediates are sign-extended from instr[31].

Test Plan:
- Reset with the slot full: assert RESET mid-hold → out_valid and all payload outputs are 0 immediately, before the next clock edge.
- Back-to-back issue with out_ready = 1, inputs 0x002081B3 (add x3,x1,x2), then 0x402081B3 (sub), then 0x022081B3 (mul):
  - Three consecutive out_valid cycles, selects ADD, SUB, MUL.
  - rs1 = 1, rs2 = 2, rd = 3, data2_imm = 0.
- Back-pressure: present 0x0220C1B3 (div) with out_ready = 0 for 3 cycles → payload stable with select DIV, in_ready = 0; release → a next instruction is accepted the same cycle.
- Immediate forms:
  - 0x40335293 (srai x5,x6,3) → SRA, imm = 3, data2_imm = 1.
  - 0x123452B7 (lui x5,0x12345) → forward code, imm = 0x12345000.
- Flush colliding with in_valid and a full slot → out_valid = 0 next cycle, incoming instruction dropped.
- Illegal: 0xFE2081B3 (funct7 = 1111111) → out_illegal = 1, reg_write = 0, slot still handshakes.
